// File: rtl/pipe_pkg.sv
// Shared types for the five-stage pipeline sequencer: FSM state encoding and
// default register-index width.
package pipe_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } pipe_state_t;

  localparam int REG_ADDR_W_DEF = 5;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds the ID instruction.
// Register x0 is hard-wired to zero and never produces a hazard.
module pipe_hazard_detect
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_is_load,
  output logic                  hazard
);

  logic rd_nonzero;
  logic rs1_hit;
  logic rs2_hit;

  assign rd_nonzero = (ex_rd != {REG_ADDR_W{1'b0}});
  assign rs1_hit    = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit    = id_use_rs2 && (id_rs2 == ex_rd);
  assign hazard     = ex_is_load && rd_nonzero && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: per-stage stall/flush controls, memory waits and ebreak halt.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
`ifdef PIPE_CTRL_PERF_EN
  ,
  parameter int PERF_W = 32
`endif
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_is_load,
  input  logic                  ex_redirect,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  input  logic                  wb_ebreak,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  id_ex_stall,
  output logic                  ex_mem_stall,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  mem_wb_flush,
  output logic                  halted
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0]     perf_stall_cnt,
  output logic [PERF_W-1:0]     perf_flush_cnt
`endif
);

  pipe_state_t state_r;
  logic        halted_r;
  logic        load_use;
  logic        mem_busy;

  pipe_hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_rd      (ex_rd),
    .ex_is_load (ex_is_load),
    .hazard     (load_use)
  );

  assign mem_busy = mem_req && !mem_ready;
  assign halted   = halted_r;

  // Sequencer state and sticky halt flag
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_r  <= BOOT;
      halted_r <= 1'b0;
    end else begin
      case (state_r)
        BOOT: begin
          state_r  <= RUN;
          halted_r <= 1'b0;
        end
        RUN: begin
          if (wb_ebreak) begin
            state_r  <= HALT;
            halted_r <= 1'b1;
          end else if (mem_busy) begin
            state_r  <= MEM_WAIT;
          end else begin
            state_r  <= RUN;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state_r <= RUN;
          end else begin
            state_r <= MEM_WAIT;
          end
        end
        HALT: begin
          state_r  <= HALT;
          halted_r <= 1'b1;
        end
        default: begin
          state_r  <= BOOT;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

  // Same-cycle stall/flush decode; a frozen MEM_WAIT ignores redirects and
  // load-use because EX and ID are held and re-evaluate once back in RUN.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    case (state_r)
      BOOT: begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        mem_wb_flush = 1'b1;
      end
      RUN: begin
        if (wb_ebreak || mem_busy) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_stall  = 1'b1;
          ex_mem_stall = 1'b1;
          mem_wb_flush = 1'b1;
        end else if (ex_redirect) begin
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
        end else if (load_use) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_flush  = 1'b1;
        end else begin
          pc_stall     = 1'b0;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_stall  = 1'b1;
          ex_mem_stall = 1'b1;
          mem_wb_flush = 1'b1;
        end else begin
          pc_stall     = 1'b0;
        end
      end
      HALT: begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
      end
      default: begin
        pc_stall     = 1'b0;
      end
    endcase
  end

`ifdef PIPE_CTRL_PERF_EN
  logic             any_flush;
  logic [PERF_W-1:0] cnt_one;

  assign any_flush = if_id_flush || id_ex_flush || mem_wb_flush;
  assign cnt_one   = {{(PERF_W-1){1'b0}}, 1'b1};

  // Stall/flush cycle counters, wrapping at 2^PERF_W
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      perf_stall_cnt <= {PERF_W{1'b0}};
      perf_flush_cnt <= {PERF_W{1'b0}};
    end else begin
      if (pc_stall && (state_r != HALT)) begin
        perf_stall_cnt <= perf_stall_cnt + cnt_one;
      end else begin
        perf_stall_cnt <= perf_stall_cnt;
      end
      if (any_flush && (state_r != BOOT)) begin
        perf_flush_cnt <= perf_flush_cnt + cnt_one;
      end else begin
        perf_flush_cnt <= perf_flush_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; counter checks are compiled in
// when PIPE_CTRL_PERF_EN is defined.
module tb_pipe_ctrl;

  logic       sys_clk;
  logic       sys_rst;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] ex_rd;
  logic       ex_is_load;
  logic       ex_redirect;
  logic       mem_req;
  logic       mem_ready;
  logic       wb_ebreak;
  logic       pc_stall;
  logic       if_id_stall;
  logic       id_ex_stall;
  logic       ex_mem_stall;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       mem_wb_flush;
  logic       halted;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // {pc, if_id, id_ex, ex_mem stall, if_id, id_ex, mem_wb flush, halted}
  logic [7:0] obs;
  assign obs = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                if_id_flush, id_ex_flush, mem_wb_flush, halted};

  localparam logic [7:0] V_ZERO = 8'b0000_000_0;
  localparam logic [7:0] V_BOOT = 8'b0000_111_0;
  localparam logic [7:0] V_LU   = 8'b1100_010_0;
  localparam logic [7:0] V_RED  = 8'b0000_110_0;
  localparam logic [7:0] V_FRZ  = 8'b1111_001_0;
  localparam logic [7:0] V_HLT  = 8'b1111_000_1;

  pipe_ctrl dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_rd        (ex_rd),
    .ex_is_load   (ex_is_load),
    .ex_redirect  (ex_redirect),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .wb_ebreak    (wb_ebreak),
    .pc_stall     (pc_stall),
    .if_id_stall  (if_id_stall),
    .id_ex_stall  (id_ex_stall),
    .ex_mem_stall (ex_mem_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .mem_wb_flush (mem_wb_flush),
    .halted       (halted)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic next_cycle;
    @(posedge sys_clk);
    #2;
  endtask

  task automatic clr;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_is_load = 1'b0; ex_redirect = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; wb_ebreak = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [7:0] exp);
    #1;
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

`ifdef PIPE_CTRL_PERF_EN
  task automatic chk_cnt(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
    end
  endtask
`endif

  initial begin
    clr();
    sys_rst = 1'b0;
    #3;
    chk("rst_boot", V_BOOT);
    #3;
    sys_rst = 1'b1;
    chk("boot_cycle", V_BOOT);
    next_cycle();
    chk("run_idle", V_ZERO);

    // load-use on rs2, then the bubble has moved into EX
    ex_is_load = 1'b1; ex_rd = 5'd5; id_use_rs2 = 1'b1; id_rs2 = 5'd5;
    chk("load_use_rs2", V_LU);
    next_cycle();
    ex_is_load = 1'b0;
    chk("load_use_done", V_ZERO);
    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
    chk("x0_no_hazard", V_ZERO);
    clr();
    ex_is_load = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7;
    chk("rs1_unused", V_ZERO);
    id_use_rs1 = 1'b1;
    chk("load_use_rs1", V_LU);
    ex_redirect = 1'b1;
    chk("redirect_prio", V_RED);
    next_cycle();
    clr();

    // three wait cycles with a redirect held through the freeze
    mem_req = 1'b1; ex_redirect = 1'b1;
    ex_is_load = 1'b1; ex_rd = 5'd3; id_use_rs1 = 1'b1; id_rs1 = 5'd3;
    chk("mem_wait_0", V_FRZ);
    next_cycle();
    chk("mem_wait_1", V_FRZ);
    next_cycle();
    chk("mem_wait_2", V_FRZ);
    next_cycle();
    mem_ready = 1'b1;
    chk("mem_release", V_ZERO);
    next_cycle();
    mem_req = 1'b0; mem_ready = 1'b0;
    chk("redirect_after_wait", V_RED);
    next_cycle();
    clr();

    mem_req = 1'b1; mem_ready = 1'b1;
    chk("mem_zero_wait", V_ZERO);
    next_cycle();
    clr();
    chk("no_wait_state", V_ZERO);

    // reset while frozen in MEM_WAIT
    mem_req = 1'b1;
    next_cycle();
    chk("wait_before_rst", V_FRZ);
    sys_rst = 1'b0;
    chk("rst_in_wait", V_BOOT);
    clr();
    next_cycle();
    sys_rst = 1'b1;
    next_cycle();
    chk("run_after_wait_rst", V_ZERO);

    // ebreak halt, sticky for 100 cycles regardless of inputs
    wb_ebreak = 1'b1;
    chk("ebreak_cycle", V_FRZ);
    next_cycle();
    clr();
    chk("halted_rise", V_HLT);
    mem_req = 1'b1; ex_redirect = 1'b1; ex_is_load = 1'b1;
    ex_rd = 5'd9; id_use_rs1 = 1'b1; id_rs1 = 5'd9;
    for (int i = 0; i < 100; i++) begin
      next_cycle();
      mem_ready = i[0];
      chk("halt_sticky", V_HLT);
    end
    sys_rst = 1'b0;
    chk("rst_in_halt", V_BOOT);
    clr();
    next_cycle();
    sys_rst = 1'b1;
    chk("boot_after_halt", V_BOOT);
    next_cycle();
    chk("run_after_halt", V_ZERO);

`ifdef PIPE_CTRL_PERF_EN
    chk_cnt("perf_stall_rst", perf_stall_cnt, 32'd0);
    chk_cnt("perf_flush_rst", perf_flush_cnt, 32'd0);
    ex_is_load = 1'b1; ex_rd = 5'd4; id_use_rs2 = 1'b1; id_rs2 = 5'd4;
    chk("perf_load_use", V_LU);
    next_cycle();
    clr();
    ex_redirect = 1'b1;
    chk("perf_redirect", V_RED);
    next_cycle();
    clr();
    next_cycle();
    chk_cnt("perf_stall_cnt", perf_stall_cnt, 32'd1);
    chk_cnt("perf_flush_cnt", perf_flush_cnt, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencer for the five-stage core. It consumes hazard and event indications from the ID, EX, MEM and WB stages and drives the per-stage stall (hold) and flush (bubble) controls of the PC register and of the if_id, id_ex, ex_mem and mem_wb pipeline registers. It implements load-use bubbles, branch/jump redirect flushes, multi-cycle data-memory waits and the ebreak halt. It replaces the single shared `valid` currently tied to all pipeline registers.

## Interface
- REG_ADDR_W, 5, architectural register index width
- PERF_W, 32, width of performance counters (only with PIPE_CTRL_PERF_EN)

Ports:
- sys_clk  in  1  core clock, all state on rising edge
- sys_rst  in  1  asynchronous, active-low reset
- id_rs1, id_rs2  in  REG_ADDR_W  source indices of instruction in ID
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2
- ex_rd  in  REG_ADDR_W  destination of instruction in EX
- ex_is_load  in  1  EX instruction is a load (valid-qualified upstream)
- ex_redirect  in  1  EX resolved a taken branch/jump (pc_sel)
- mem_req  in  1  MEM stage issuing a data-memory access
- mem_ready  in  1  data memory completes access this cycle
- wb_ebreak  in  1  ebreak committing in WB
- pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1  hold register contents
- if_id_flush, id_ex_flush, mem_wb_flush  out  1  load bubble (valid=0) on next edge
- halted  out  1  core halted by ebreak
- perf_stall_cnt, perf_flush_cnt  out  PERF_W  (PIPE_CTRL_PERF_EN only)

## Operation
- States: BOOT, RUN, MEM_WAIT, HALT. Reset (sys_rst=0) forces BOOT asynchronously.
- BOOT: all flushes=1, all stalls=0, halted=0; unconditionally -> RUN next edge.
- RUN, evaluated in priority order:
  1. wb_ebreak: -> HALT; this cycle all stalls=1, mem_wb_flush=1.
  2. mem_req && !mem_ready: -> MEM_WAIT; pc/if_id/id_ex/ex_mem stall=1, mem_wb_flush=1.
  3. ex_redirect: if_id_flush=1, id_ex_flush=1, no stalls (PC loads target).
  4. load-use (ex_is_load && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd))): pc_stall=1, if_id_stall=1, id_ex_flush=1.
  5. else all outputs 0.
- MEM_WAIT: same outputs as RUN rule 2 while !mem_ready; on mem_ready -> RUN with all outputs 0 that cycle (ex_mem and mem_wb advance normally). ex_redirect and load-use are ignored while frozen; because EX/ID are held, they re-evaluate in RUN.
- HALT: all stalls=1, all flushes=0, halted=1; sticky until reset.
- Register x0 never creates a load-use hazard.
- Stall and flush of the same register are never both asserted.

## Timing
- State registered; stall/flush outputs combinational from state and current inputs (same-cycle response).
- Reset values: state=BOOT, halted=0, counters=0; outputs during reset follow BOOT decode.
- Load-use costs exactly 1 bubble cycle; redirect costs 2 flushed slots; MEM_WAIT lasts until first mem_ready cycle (0 extra cycles if mem_ready with mem_req).
- Reset asserted mid-MEM_WAIT or in HALT returns to BOOT immediately.
- halted rises the cycle after wb_ebreak is sampled.

## Configuration
- PIPE_CTRL_PERF_EN defined: perf_stall_cnt increments each cycle pc_stall=1 and state!=HALT; perf_flush_cnt increments each cycle any flush=1 and state!=BOOT; both wrap at 2^PERF_W, clear on reset.
- Undefined: counter ports and logic absent.

## Structure
- Shared package pipe_pkg: state enum (BOOT, RUN, MEM_WAIT, HALT) with fixed 2-bit encodings 0-3, REG_ADDR_W default constant.
- One sub-module: pipe_hazard_detect (combinational load-use compare, output hazard bit).

## Test plan
- Reset release -> exactly one cycle all flushes=1, then RUN with all outputs 0.
- ex_is_load=1, ex_rd=5, id_use_rs2=1, id_rs2=5 -> pc_stall=if_id_stall=id_ex_flush=1 for one cycle; same with ex_rd=0 -> no stall.
- ex_redirect=1 together with load-use condition -> only if_id_flush and id_ex_flush=1, no stalls.
- mem_req=1, mem_ready=0 for 3 cycles then 1 -> 3 cycles of upstream stalls plus mem_wb_flush, release on the ready cycle; ex_redirect held through wait acted on afterward.
- wb_ebreak=1 -> halted=1 next cycle, all stalls=1 persist 100 cycles; sys_rst low mid-HALT -> BOOT.
- PIPE_CTRL_PERF_EN: 1 load-use + 1 redirect -> perf_stall_cnt=1, perf_flush_cnt=2.
